// File: rtl/nwc_job_ctrl_if.sv
// Handshake bundle between the host, the NWC core and the job controller.
// The master modport is the controller's view; the slave modport is the environment's view.
interface nwc_job_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             core_start;
  logic             core_start_ready;
  logic             core_memory_writable;
  logic             core_output_ready;
  logic             in_mem_owner;
  logic             out_mem_owner;
  logic             done_valid;
  logic             done_ready;
  logic             busy;
  logic [CNT_W-1:0] job_count;

  modport master (
    input  req_valid, core_start_ready, core_memory_writable, core_output_ready, done_ready,
    output req_ready, core_start, in_mem_owner, out_mem_owner, done_valid, busy, job_count
  );

  modport slave (
    output req_valid, core_start_ready, core_memory_writable, core_output_ready, done_ready,
    input  req_ready, core_start, in_mem_owner, out_mem_owner, done_valid, busy, job_count
  );
endinterface

// File: rtl/nwc_job_ctrl.sv
// Job sequencer handing input/output memories between host and NWC core.
// Define NWC_JOB_CTRL_TIMEOUT_EN to add the RUN watchdog and the sticky err_timeout port.
module nwc_job_ctrl #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  nwc_job_ctrl_if.master   bus
`ifdef NWC_JOB_CTRL_TIMEOUT_EN
  ,
  output logic             err_timeout
`endif
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARM  = 3'd1;
  localparam logic [2:0] KICK = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;

  // The watchdog compares against TIMEOUT_CYCLES-1, so anything below 2 is meaningless.
  if (TIMEOUT_CYCLES < 2 || CNT_W < 1) begin : g_bad_params
    $error("nwc_job_ctrl: TIMEOUT_CYCLES must be >= 2 and CNT_W >= 1");
  end

  logic [2:0]       state;
  logic             in_own;
  logic             out_own;
  logic [CNT_W-1:0] job_cnt;

`ifdef NWC_JOB_CTRL_TIMEOUT_EN
  localparam int             TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] run_cnt;
  logic            err_q;
  logic            run_expired;

  assign run_expired = (run_cnt == TO_LAST);
  assign err_timeout = err_q;

  // KICK always leads into RUN, so clearing there restarts the count on RUN entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == KICK) begin
        run_cnt <= '0;
      end else if (state == RUN) begin
        run_cnt <= run_cnt + 1'b1;
      end
      if (state == RUN && !bus.core_output_ready && run_expired) begin
        err_q <= 1'b1;
      end
    end
  end
`endif

  // Ownership bits move with the FSM; reaching HOLD always hands both memories back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      in_own  <= 1'b0;
      out_own <= 1'b0;
      job_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state <= ARM;
          end
        end
        ARM: begin
          if (bus.core_start_ready) begin
            state   <= KICK;
            in_own  <= 1'b1;
            out_own <= 1'b1;
          end
        end
        KICK: begin
          state <= RUN;
          if (bus.core_memory_writable) begin
            in_own <= 1'b0;
          end
        end
        RUN: begin
          if (bus.core_output_ready) begin
            state   <= HOLD;
            in_own  <= 1'b0;
            out_own <= 1'b0;
          end
`ifdef NWC_JOB_CTRL_TIMEOUT_EN
          else if (run_expired) begin
            state   <= IDLE;
            in_own  <= 1'b0;
            out_own <= 1'b0;
          end
`endif
          else if (bus.core_memory_writable) begin
            in_own <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.done_ready) begin
            state   <= IDLE;
            job_cnt <= job_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.core_start    = (state == KICK);
  assign bus.done_valid    = (state == HOLD);
  assign bus.busy          = (state != IDLE);
  assign bus.in_mem_owner  = in_own;
  assign bus.out_mem_owner = out_own;
  assign bus.job_count     = job_cnt;

endmodule
